serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled on the rising clk edge.
REQ-005 Port: a  input  WIDTH  minuend; sampled only on the edge that accepts start.
REQ-006 Port: b  input  WIDTH  subtrahend; sampled only on the edge that accepts start.
REQ-007 Port: busy  output  1  high in RUN and DONE states.
REQ-008 Port: done  output  1  one-cycle pulse; result valid.
REQ-009 Port: diff  output  WIDTH  registered result a-b, modulo 2^WIDTH.
REQ-010 Port: bout  output  1  final borrow out; 1 when unsigned a < b.
REQ-011 Port: ovf  output  1  signed (two's-complement) overflow of a-b.

Function
REQ-012 The block SHALL be a bit-serial subtractor: one full-subtractor cell plus one borrow flip-flop, LSB first, one bit per clk cycle.
REQ-013 Per-bit equations SHALL be: d = ai ^ bi ^ br; br_next = (~ai & bi) | (~(ai ^ bi) & br).
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 IDLE -> RUN on a clk edge with start=1. On that edge the block SHALL latch a and b into internal shift registers, clear the borrow flip-flop, and clear the bit counter to 0.
REQ-016 In RUN, each edge SHALL process bit[count], shift the difference bit into the result shift register and increment count.
REQ-017 RUN -> DONE on the edge that processes bit WIDTH-1. On that edge the block SHALL load diff, bout (the final borrow) and ovf.
REQ-018 ovf SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operands.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle; DONE -> IDLE unconditionally on the next edge.
REQ-020 Latency: done SHALL be high in the cycle after WIDTH+1 rising edges, counting the accepting edge; for WIDTH=8 that is 9 edges.
REQ-021 start SHALL be ignored while busy=1 (RUN or DONE); no re-latch and no restart.
REQ-022 A start held high continuously SHALL launch back-to-back operations, one every WIDTH+2 cycles.
REQ-023 diff, bout and ovf SHALL hold their last loaded values until the next DONE load; they SHALL NOT change during RUN.
REQ-024 Changes on a or b SHALL have no effect except on the accepting edge.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=IDLE, count=0, borrow=0, shift registers=0, busy=0, done=0, diff=0, bout=0 and ovf=0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation: no done pulse, and outputs are cleared.
REQ-027 The first start SHALL be accepted on the first rising edge with rst_n=1.

Verification (WIDTH=8)
REQ-028 a=0x05, b=0x03, start pulse -> after 9 edges done=1 with diff=0x02, bout=0, ovf=0.
REQ-029 a=0x03, b=0x05 -> diff=0xFE, bout=1, ovf=0; a=0x00, b=0x00 -> diff=0x00, bout=0, ovf=0.
REQ-030 a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1; a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
REQ-031 Launch a=0x10, b=0x01, then pulse start again with a=0xFF, b=0xFF at RUN cycle 3 -> single done pulse with diff=0x0F; second request ignored; busy stays high 9 cycles.
REQ-032 Launch a=0xAA, b=0x55, assert rst_n=0 at RUN cycle 4 -> outputs=0 immediately with no clock edge, no done pulse; after release a new start a=0xAA, b=0x55 -> diff=0x55, bout=0, ovf=1.
REQ-033 start held high for 30 cycles with a=0x09, b=0x04 -> done pulses every 10 cycles, each with diff=0x05.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, using a
// single full-subtractor cell and a borrow flip-flop.
//
// Handshake: start is sampled on each rising edge while the block is idle
// (busy=0). The edge that accepts start also latches a and b. Exactly WIDTH
// edges later the result is loaded, and done pulses for one cycle. While
// busy=1, start is ignored. diff/bout/ovf hold their values between loads.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    // Full-subtractor cell operating on the current LSBs of the shift registers.
    logic ai, bi, d_bit, br_next;
    assign ai      = a_sh_q[0];
    assign bi      = b_sh_q[0];
    assign d_bit   = ai ^ bi ^ br_q;
    assign br_next = (~ai & bi) | (~(ai ^ bi) & br_q);

    // State and datapath registers; reset clears everything, aborting any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            br_q    <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            br_q    <= br_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath logic: latch on accept, shift one bit per RUN cycle,
    // load the visible result on the cycle that consumes the MSB.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        br_d    = br_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    br_d    = 1'b0;
                    count_d = '0;
                    res_d   = '0;
                end
            end
            RUN: begin
                // Result enters at the MSB so after WIDTH shifts bit 0 lands at position 0.
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                br_d    = br_next;
                res_d   = {d_bit, res_q[WIDTH-1:1]};
                count_d = count_q + CW'(1);
                if (count_q == LAST_BIT) begin
                    state_d = DONE;
                    count_d = '0;
                    diff_d  = {d_bit, res_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    // ai/bi are the latched operand MSBs at this point; d_bit is the result MSB.
                    ovf_d   = (ai != bi) && (d_bit != ai);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == RUN) || (state_q == DONE);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH=8): directed spec vectors, randomized
// operations against an arithmetic reference model, start-while-busy, mid-run
// reset, and back-to-back operation with start held high.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard entries are {ovf, bout, diff}.
    logic [W+1:0] exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    // Clock and reset-time stimulus defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain arithmetic on the operands
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
        logic [W-1:0]    d;
        logic            br;
        logic            ov;
        int              sa;
        int              sb;
        int              sr;
        d  = ma - mb;
        br = (ma < mb);
        sa = ma[W-1] ? int'(ma) - (1 << W) : int'(ma);
        sb = mb[W-1] ? int'(mb) - (1 << W) : int'(mb);
        sr = sa - sb;
        ov = (sr > ((1 << (W - 1)) - 1)) || (sr < -(1 << (W - 1)));
        return {ov, br, d};
    endfunction

    // Driver: caller is at a negedge. Launch one operation, check latency,
    // output hold during RUN, result against the scoreboard, and the return to idle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
        logic [W+1:0] held;
        logic [W+1:0] exp_v;
        logic         hold_bad;
        int           cyc;
        exp_q.push_back(model(ta, tb_v));
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        @(negedge clk);
        start    = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cyc      = 1;
        held     = {ovf, bout, diff};
        hold_bad = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL accept_busy a=%h b=%h: busy=%b expected 1", ta, tb_v, busy);
        end
        while (done !== 1'b1 && cyc < 20) begin
            if ({ovf, bout, diff} !== held) hold_bad = 1'b1;
            @(negedge clk);
            cyc++;
            a = W'($urandom);
            b = W'($urandom);
        end
        n_checks++;
        if (cyc != W + 1) begin
            n_errors++;
            $display("FAIL latency a=%h b=%h: done after %0d edges expected %0d", ta, tb_v, cyc, W + 1);
        end
        n_checks++;
        if (hold_bad) begin
            n_errors++;
            $display("FAIL hold_during_run a=%h b=%h: outputs changed before done, start value %h", ta, tb_v, held);
        end
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: got %h with no expected entry", {ovf, bout, diff});
        end else begin
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({ovf, bout, diff} !== exp_v) begin
                n_errors++;
                $display("FAIL result a=%h b=%h: got ovf=%b bout=%b diff=%h expected ovf=%b bout=%b diff=%h",
                         ta, tb_v, ovf, bout, diff, exp_v[W+1], exp_v[W], exp_v[W-1:0]);
            end
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL done_pulse a=%h b=%h: done=%b busy=%b expected 0 0", ta, tb_v, done, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h5A;
        b     = 8'hA5;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, bout, ovf, diff} !== '0) begin
            n_errors++;
            $display("FAIL reset_state: busy=%b done=%b bout=%b ovf=%b diff=%h expected all 0",
                     busy, done, bout, ovf, diff);
        end
    endtask

    // Release reset and raise start on the same negedge: the first edge must accept.
    task automatic test_first_start();
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h05, 8'h03);
    endtask

    task automatic test_directed();
        logic [W-1:0] va[5];
        logic [W-1:0] vb[5];
        va = '{8'h03, 8'h00, 8'h80, 8'h7F, 8'hFF};
        vb = '{8'h05, 8'h00, 8'h01, 8'hFF, 8'h00};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            run_op(va[i], vb[i]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            run_op(W'($urandom), W'($urandom));
        end
    endtask

    // A second start during RUN must be ignored.
    task automatic test_ignore_start();
        int busy_cnt;
        int done_cnt;
        int done_at;
        logic [W-1:0] done_diff;
        busy_cnt  = 0;
        done_cnt  = 0;
        done_at   = -1;
        done_diff = '0;
        @(negedge clk);
        start = 1'b1;
        a     = 8'h10;
        b     = 8'h01;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at   = i;
                done_diff = diff;
            end
            if (i == 2) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++;
        if (done_cnt != 1 || done_at != W) begin
            n_errors++;
            $display("FAIL ignore_start_done: %0d pulses at %0d expected 1 at %0d", done_cnt, done_at, W);
        end
        n_checks++;
        if (done_diff !== 8'h0F) begin
            n_errors++;
            $display("FAIL ignore_start_diff: diff=%h expected 0f", done_diff);
        end
        n_checks++;
        if (busy_cnt != W + 1) begin
            n_errors++;
            $display("FAIL ignore_start_busy: busy for %0d cycles expected %0d", busy_cnt, W + 1);
        end
    endtask

    // Reset asserted mid-RUN clears outputs without a clock edge and suppresses done.
    task automatic test_mid_run_reset();
        int done_cnt;
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, bout, ovf, diff} !== '0) begin
            n_errors++;
            $display("FAIL async_reset: busy=%b done=%b bout=%b ovf=%b diff=%h expected all 0",
                     busy, done, bout, ovf, diff);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        n_checks++;
        if (done_cnt != 0) begin
            n_errors++;
            $display("FAIL abort_no_done: %0d done pulses expected 0", done_cnt);
        end
        @(negedge clk);
        run_op(8'hAA, 8'h55);
    endtask

    // start held high for 30 cycles: pulses every W+2 cycles.
    task automatic test_back_to_back();
        int pulses;
        int last;
        int bad_gap;
        int bad_diff;
        pulses   = 0;
        last     = -1;
        bad_gap  = 0;
        bad_diff = 0;
        @(negedge clk);
        start = 1'b1;
        a     = 8'h09;
        b     = 8'h04;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 30) start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                if (last < 0) begin
                    if (i != W + 1) bad_gap++;
                end else if (i - last != W + 2) begin
                    bad_gap++;
                end
                if (diff !== 8'h05) bad_diff++;
                last = i;
            end
        end
        n_checks++;
        if (pulses != 3) begin
            n_errors++;
            $display("FAIL b2b_count: %0d pulses expected 3", pulses);
        end
        n_checks++;
        if (bad_gap != 0) begin
            n_errors++;
            $display("FAIL b2b_spacing: %0d irregular pulses expected 0", bad_gap);
        end
        n_checks++;
        if (bad_diff != 0) begin
            n_errors++;
            $display("FAIL b2b_diff: %0d pulses with diff!=05 expected 0", bad_diff);
        end
    endtask

    initial begin
        test_reset();
        test_first_start();
        test_directed();
        test_random();
        test_ignore_start();
        test_mid_run_reset();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule
